// File: rtl/cpu_seq_pkg.sv
// Shared types and constants for the SM83 machine-cycle sequencer.
package cpu_seq_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      EXEC  = 2'd1,
      HALT  = 2'd2,
      INT   = 2'd3
   } seq_state_t;

   localparam logic [1:0] T1 = 2'd0;
   localparam logic [1:0] T2 = 2'd1;
   localparam logic [1:0] T3 = 2'd2;
   localparam logic [1:0] T4 = 2'd3;

   localparam logic [7:0] OPC_CB   = 8'hCB;
   localparam logic [7:0] OPC_HALT = 8'h76;

   localparam int MAX_MCYC_DEF = 6;
   localparam int INT_MCYC_DEF = 5;

endpackage

// File: rtl/cpu_tcyc_ctr.sv
// T-cycle counter: T1..T4 phase with clock enable and a T4 strobe.
module cpu_tcyc_ctr
   import cpu_seq_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       ce,
   output logic [1:0] t_idx,
   output logic       t4
);

   logic [1:0] r_t;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_t <= T1;
      else if (ce) r_t <= r_t + 2'd1;
   end

   assign t_idx = r_t;
   assign t4    = ce && (r_t == T4);

endmodule

// File: rtl/cpu_mcyc_seq.sv
// SM83 machine-cycle sequencer: M-cycle index, opcode fetch, CB prefix,
// and instruction-boundary arbitration between fetch, HALT and interrupt.
//
// state | meaning
// FETCH | M1 opcode fetch, IR loaded at T4
// EXEC  | decoder-driven M-cycles after the fetch
// HALT  | core halted, waiting for an interrupt request
// INT   | interrupt dispatch, fixed INT_MCYC M-cycles
module cpu_mcyc_seq
   import cpu_seq_pkg::*;
#(
   parameter int MAX_MCYC = MAX_MCYC_DEF,
   parameter int INT_MCYC = INT_MCYC_DEF
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       ce,
   input  logic [7:0] din,
   input  logic       dec_last,
   input  logic       dec_halt,
   input  logic       dec_cb,
   input  logic       ime,
   input  logic       irq_pending,
   output logic [1:0] t_idx,
   output logic [2:0] m_idx,
   output logic [7:0] ir,
   output logic       cb,
   output logic       fetch,
   output logic       rd,
   output logic       pc_inc,
   output logic       halted,
   output logic       int_dispatch,
   output logic       int_ack
);

   seq_state_t r_state, w_state_nxt;
   logic [2:0] r_m_idx, w_m_nxt;
   logic [7:0] r_ir, w_ir_nxt;
   logic       r_cb, w_cb_nxt;
   logic       r_prefix, w_prefix_nxt;
   logic       r_halt_bug, w_hb_nxt;
   logic       w_t4, w_last, w_prefix_set, w_boundary;

   cpu_tcyc_ctr u_tcyc (
      .clk   (clk),
      .reset (reset),
      .ce    (ce),
      .t_idx (t_idx),
      .t4    (w_t4)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= FETCH;
         r_m_idx    <= 3'd1;
         r_ir       <= 8'h00;
         r_cb       <= 1'b0;
         r_prefix   <= 1'b0;
         r_halt_bug <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_m_idx    <= w_m_nxt;
         r_ir       <= w_ir_nxt;
         r_cb       <= w_cb_nxt;
         r_prefix   <= w_prefix_nxt;
         r_halt_bug <= w_hb_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_m_nxt      = r_m_idx;
      w_ir_nxt     = r_ir;
      w_cb_nxt     = r_cb;
      w_prefix_nxt = r_prefix;
      w_hb_nxt     = r_halt_bug;
      w_boundary   = 1'b0;
      w_last       = dec_last || (r_m_idx == 3'(MAX_MCYC));
      // The second byte of a CB pair must not re-arm the prefix, even if it is 0xCB.
      w_prefix_set = dec_cb && !r_cb && !r_prefix;
      if (w_t4) begin
         case (r_state)
            FETCH: begin
               w_ir_nxt     = din;
               w_cb_nxt     = r_prefix;
               w_prefix_nxt = 1'b0;
               w_hb_nxt     = 1'b0;
               if (w_last) w_boundary = 1'b1;
               else begin
                  w_state_nxt = EXEC;
                  w_m_nxt     = r_m_idx + 3'd1;
               end
            end
            EXEC: begin
               if (w_last) w_boundary = 1'b1;
               else w_m_nxt = r_m_idx + 3'd1;
            end
            HALT: begin
               if (irq_pending) w_state_nxt = ime ? INT : FETCH;
            end
            INT: begin
               if (r_m_idx == 3'(INT_MCYC)) begin
                  w_state_nxt = FETCH;
                  w_m_nxt     = 3'd1;
               end else begin
                  w_m_nxt = r_m_idx + 3'd1;
               end
            end
            default: ;
         endcase
         if (w_boundary) begin
            w_m_nxt = 3'd1;
            if (w_prefix_set) w_prefix_nxt = 1'b1;
            if (dec_halt) begin
               if (!ime && irq_pending) begin
                  w_state_nxt = FETCH;
                  w_hb_nxt    = 1'b1;
               end else begin
                  w_state_nxt = HALT;
               end
            end else if (ime && irq_pending && !w_prefix_nxt) begin
               w_state_nxt = INT;
            end else begin
               w_state_nxt = FETCH;
            end
         end
      end
   end

   assign m_idx        = r_m_idx;
   assign ir           = r_ir;
   assign cb           = r_cb;
   assign fetch        = (r_state == FETCH);
   assign rd           = fetch && (t_idx != T4);
   assign halted       = (r_state == HALT);
   assign int_dispatch = (r_state == INT);
   assign pc_inc       = w_t4 && fetch && !r_halt_bug;
   assign int_ack      = w_t4 && int_dispatch && (r_m_idx == 3'd4);

endmodule

// File: tb/tb_cpu_mcyc_seq.sv
// Scoreboard bench for cpu_mcyc_seq: per-M-cycle expectations checked at T4.
module tb_cpu_mcyc_seq;

   typedef struct packed {
      logic       f;
      logic       h;
      logic       i;
      logic [2:0] m;
      logic       pc;
      logic       ack;
      logic [7:0] ir;
      logic       cb;
   } mrec_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       ce = 1'b1;
   logic [7:0] din = 8'h00;
   logic       dec_last = 1'b0, dec_halt = 1'b0, dec_cb = 1'b0;
   logic       ime = 1'b0, irq_pending = 1'b0;
   logic [1:0] t_idx;
   logic [2:0] m_idx;
   logic [7:0] ir;
   logic       cb, fetch, rd, pc_inc, halted, int_dispatch, int_ack;

   int    n_checks = 0;
   int    n_err = 0;
   int    n_mcyc = 0;
   int    rd_in_halt = 0;
   logic  mon_en = 1'b0;
   mrec_t q[$];

   cpu_mcyc_seq dut (
      .clk(clk), .reset(reset), .ce(ce), .din(din),
      .dec_last(dec_last), .dec_halt(dec_halt), .dec_cb(dec_cb),
      .ime(ime), .irq_pending(irq_pending),
      .t_idx(t_idx), .m_idx(m_idx), .ir(ir), .cb(cb), .fetch(fetch), .rd(rd),
      .pc_inc(pc_inc), .halted(halted), .int_dispatch(int_dispatch), .int_ack(int_ack)
   );

   always #5 clk = ~clk;

   function automatic mrec_t F(logic [2:0] m, logic pc, logic [7:0] r, logic c);
      return '{f:1'b1, h:1'b0, i:1'b0, m:m, pc:pc, ack:1'b0, ir:r, cb:c};
   endfunction
   function automatic mrec_t X(logic [2:0] m, logic [7:0] r, logic c);
      return '{f:1'b0, h:1'b0, i:1'b0, m:m, pc:1'b0, ack:1'b0, ir:r, cb:c};
   endfunction
   function automatic mrec_t H(logic [7:0] r, logic c);
      return '{f:1'b0, h:1'b1, i:1'b0, m:3'd1, pc:1'b0, ack:1'b0, ir:r, cb:c};
   endfunction
   function automatic mrec_t I(logic [2:0] m, logic [7:0] r, logic c);
      return '{f:1'b0, h:1'b0, i:1'b1, m:m, pc:1'b0, ack:(m == 3'd4), ir:r, cb:c};
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // One M-cycle: drive decoder/bus inputs, queue the expected T4 snapshot.
   task automatic mc(input logic [7:0] d, input logic l, input logic hl, input logic c,
                     input logic ie, input logic iq, input mrec_t e);
      din = d; dec_last = l; dec_halt = hl; dec_cb = c; ime = ie; irq_pending = iq;
      q.push_back(e);
      repeat (4) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (halted && rd) rd_in_halt++;
      if (mon_en && !reset && ce && t_idx == 2'd3) begin
         mrec_t g, e;
         g = '{f:fetch, h:halted, i:int_dispatch, m:m_idx, pc:pc_inc, ack:int_ack, ir:ir, cb:cb};
         n_checks++;
         n_mcyc++;
         if (q.size() == 0) begin
            n_err++;
            $display("FAIL mcyc%0d: unexpected M-cycle end, got f%b h%b i%b m%0d", n_mcyc, g.f, g.h, g.i, g.m);
         end else begin
            e = q.pop_front();
            if (g !== e) begin
               n_err++;
               $display("FAIL mcyc%0d: got f%b h%b i%b m%0d pc%b ack%b ir%h cb%b expected f%b h%b i%b m%0d pc%b ack%b ir%h cb%b",
                        n_mcyc, g.f, g.h, g.i, g.m, g.pc, g.ack, g.ir, g.cb,
                        e.f, e.h, e.i, e.m, e.pc, e.ack, e.ir, e.cb);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] pat;
      int ones;
      @(posedge clk); #1;
      chk("rst_vals", {30'd0, t_idx} | ({29'd0, m_idx} << 2) | ({24'd0, ir} << 5), 32'h0000_0004);
      chk("rst_flags", {25'd0, cb, fetch, halted, int_dispatch, pc_inc, int_ack, rd}, {25'd0, 7'b0100001});
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      mon_en = 1'b1;

      // LD B,n
      mc(8'h06, 0, 0, 0, 0, 0, F(1, 1, 8'h00, 0));
      mc(8'h00, 1, 0, 0, 0, 0, X(2, 8'h06, 0));
      // CB prefix with interrupt pending throughout, then dispatch after 0x37
      mc(8'hCB, 1, 0, 1, 1, 1, F(1, 1, 8'h06, 0));
      mc(8'h37, 0, 0, 0, 1, 1, F(1, 1, 8'hCB, 0));
      mc(8'h00, 0, 0, 0, 1, 1, X(2, 8'h37, 1));
      mc(8'h00, 1, 0, 0, 1, 1, X(3, 8'h37, 1));
      for (int k = 1; k <= 5; k++)
         mc(8'h00, 1, 0, 0, 0, 0, I(3'(k), 8'h37, 1));
      mc(8'h00, 1, 0, 0, 0, 0, F(1, 1, 8'h37, 1));
      // HALT with ime=0, wake on irq without dispatch
      mc(8'h76, 1, 1, 0, 0, 0, F(1, 1, 8'h00, 0));
      for (int k = 0; k < 5; k++)
         mc(8'h00, 0, 0, 0, 0, 0, H(8'h76, 0));
      mc(8'h00, 0, 0, 0, 0, 1, H(8'h76, 0));
      mc(8'h00, 1, 0, 0, 0, 0, F(1, 1, 8'h76, 0));
      // HALT bug: next fetch does not advance PC
      mc(8'h76, 1, 1, 0, 0, 1, F(1, 1, 8'h00, 0));
      mc(8'h04, 1, 0, 0, 0, 0, F(1, 0, 8'h76, 0));
      mc(8'h00, 1, 0, 0, 0, 0, F(1, 1, 8'h04, 0));
      // Interrupt taken at NOP end; dec_last ignored during dispatch
      mc(8'h00, 1, 0, 0, 1, 1, F(1, 1, 8'h00, 0));
      for (int k = 1; k <= 5; k++)
         mc(8'h00, 1, 0, 0, 0, 0, I(3'(k), 8'h00, 0));
      mc(8'h00, 1, 0, 0, 0, 0, F(1, 1, 8'h00, 0));
      // Instruction forced to end at M6
      mc(8'h01, 0, 0, 0, 0, 0, F(1, 1, 8'h00, 0));
      for (int k = 2; k <= 6; k++)
         mc(8'h00, 0, 0, 0, 0, 0, X(3'(k), 8'h01, 0));
      mc(8'h00, 1, 0, 0, 0, 0, F(1, 1, 8'h01, 0));

      chk("sb_drained", q.size(), 0);
      chk("rd_in_halt", rd_in_halt, 0);
      mon_en = 1'b0;

      // Clock-enable gating
      ce = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk("ce_hold", {30'd0, t_idx}, 0);
      pat = 8'b0100_1010;
      ones = 0;
      for (int k = 0; k < 8; k++) begin
         ce = pat[k];
         if (pat[k]) ones++;
         @(posedge clk); #1;
      end
      chk("ce_count", {30'd0, t_idx}, ones % 4);
      ce = 1'b0; #1;
      chk("pc_inc_gated", {31'd0, pc_inc}, 0);
      ce = 1'b1; #1;
      chk("pc_inc_t4", {31'd0, pc_inc}, 1);

      // Async reset in EXEC M2T2
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      chk("rd_t1", {31'd0, rd}, 1);
      din = 8'h06; dec_last = 1'b0; dec_halt = 1'b0; dec_cb = 1'b0; ime = 1'b0; irq_pending = 1'b0;
      repeat (4) @(posedge clk); #1;
      chk("exec_m2", {20'd0, ir, m_idx, fetch}, {20'd0, 8'h06, 3'd2, 1'b0});
      @(posedge clk); #1;
      chk("exec_t2", {30'd0, t_idx}, 1);
      reset = 1'b1; #1;
      chk("async_rst_vals", {19'd0, t_idx, m_idx, ir}, {19'd0, 2'd0, 3'd1, 8'h00});
      chk("async_rst_flags", {25'd0, cb, fetch, halted, int_dispatch, pc_inc, int_ack, rd}, {25'd0, 7'b0100001});
      @(posedge clk); #1 reset = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("first_fetch_t4", {29'd0, t_idx, pc_inc}, {29'd0, 2'd3, 1'b1});

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
